cal_bus_arb: RTL and testbench

- Bus-side counterpart of the picture accelerator's master port. It decides who drives the shared 16-bit address / 8-bit data memory bus: the CPU (the default owner) or the accelerator.
- The accelerator asks for the bus with acc_req and is granted it with arb_res.
- During the handover the block stalls the CPU, inserts dead cycles, limits how long the accelerator may hold the bus, and turns the accelerator's done pulse into a latched CPU interrupt.

---
 rtl/cal_bus_arb.sv | 182 ++++++++++++++++++
 tb/tb_cal_bus_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_bus_arb.sv
// cal_bus_arb: decides who drives the shared memory bus. This is the bus-side
// counterpart of the picture accelerator's master port.
//
// The CPU owns the bus by default. An accelerator request takes the bus
// through this sequence: stall the CPU, wait GNT_DLY dead cycles, then grant.
// The tenure is limited to HOLD_MAX cycles. Release goes through one dead
// cycle, and the CPU is then guaranteed at least one owned cycle before the
// next grant. The accelerator's done indication becomes a latched CPU
// interrupt.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cpu_addr/cpu_data/cpu_write   CPU bus request
//   cpu_lock                      CPU multi-cycle access in flight (blocks handover)
//   cpu_hold                      CPU stall (registered)
//   acc_req / arb_res             accelerator request (level) / grant (registered)
//   acc_addr/acc_data/acc_write   accelerator bus request
//   acc_int                       accelerator done indication
//   bus_addr/bus_data/bus_write   shared memory bus
//   irq / irq_ack                 latched interrupt / clear pulse
//   arb_tmo / tmo_clr             sticky tenure-timeout flag / clear
module cal_bus_arb #(
  parameter int HOLD_MAX = 64,  // 1..255
  parameter int GNT_DLY  = 1    // 1..3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_write,
  input  logic        cpu_lock,
  output logic        cpu_hold,
  input  logic        acc_req,
  output logic        arb_res,
  input  logic [15:0] acc_addr,
  input  logic [7:0]  acc_data,
  input  logic        acc_write,
  input  logic        acc_int,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data,
  output logic        bus_write,
  output logic        irq,
  input  logic        irq_ack,
  output logic        arb_tmo,
  input  logic        tmo_clr
);

  localparam int TW = $clog2(HOLD_MAX + 1);
  localparam logic [TW-1:0] TEN_LIMIT = TW'(HOLD_MAX);
  localparam logic [1:0]    DLY_LAST  = 2'(GNT_DLY - 1);

  typedef enum logic [1:0] {CPU_OWN, TO_ACC, ACC_OWN, TO_CPU} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] ten_reg, ten_next;     // current cycle number within the tenure
  logic [1:0]    dly_reg, dly_next;     // dead cycles already spent in TO_ACC
  logic          guard_reg, guard_next; // first CPU_OWN cycle after a tenure
  logic          tmo_set;
  logic          arb_res_reg, cpu_hold_reg;
  logic          irq_reg, irq_next;
  logic          arb_tmo_reg, arb_tmo_next;
  logic          acc_int_prev_reg;
  logic [15:0]   last_addr_reg;
  logic [7:0]    last_data_reg;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    ten_next   = ten_reg;
    dly_next   = dly_reg;
    guard_next = guard_reg;
    tmo_set    = 1'b0;
    case (state_reg)
      CPU_OWN: begin
        guard_next = 1'b0;
        if (acc_req && !cpu_lock && !guard_reg) begin
          state_next = TO_ACC;
          dly_next   = 2'd0;
        end
      end
      TO_ACC: begin
        if (!acc_req) begin
          state_next = TO_CPU;
        end else if (dly_reg == DLY_LAST) begin
          state_next = ACC_OWN;
          ten_next   = TW'(1);  // the first granted cycle is cycle 1
        end else begin
          dly_next = dly_reg + 2'd1;
        end
      end
      ACC_OWN: begin
        // Saturate rather than wrap; the limit compare below exits first anyway.
        if (ten_reg < TEN_LIMIT) begin
          ten_next = ten_reg + TW'(1);
        end
        if (!acc_req) begin
          state_next = TO_CPU;
        end else if (ten_reg == TEN_LIMIT) begin
          state_next = TO_CPU;
          tmo_set    = 1'b1;
        end
      end
      TO_CPU: begin
        state_next = CPU_OWN;
        guard_next = 1'b1;
      end
      default: state_next = CPU_OWN;
    endcase
  end

  // Sticky flags. A new event wins over a simultaneous clear.
  always_comb begin
    irq_next = irq_reg;
    if (acc_int && !acc_int_prev_reg) begin
      irq_next = 1'b1;
    end else if (irq_ack) begin
      irq_next = 1'b0;
    end
    arb_tmo_next = arb_tmo_reg;
    if (tmo_set) begin
      arb_tmo_next = 1'b1;
    end else if (tmo_clr) begin
      arb_tmo_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= CPU_OWN;
      ten_reg          <= '0;
      dly_reg          <= 2'd0;
      guard_reg        <= 1'b0;
      arb_res_reg      <= 1'b0;
      cpu_hold_reg     <= 1'b0;
      irq_reg          <= 1'b0;
      arb_tmo_reg      <= 1'b0;
      acc_int_prev_reg <= 1'b0;
      last_addr_reg    <= 16'd0;
      last_data_reg    <= 8'd0;
    end else begin
      state_reg        <= state_next;
      ten_reg          <= ten_next;
      dly_reg          <= dly_next;
      guard_reg        <= guard_next;
      // Grant and stall are registered copies of the state being entered.
      arb_res_reg      <= (state_next == ACC_OWN);
      cpu_hold_reg     <= (state_next != CPU_OWN);
      irq_reg          <= irq_next;
      arb_tmo_reg      <= arb_tmo_next;
      acc_int_prev_reg <= acc_int;
      last_addr_reg    <= bus_addr;
      last_data_reg    <= bus_data;
    end
  end

  // Bus mux. The handover cycles park the bus on its last address/data
  // and never write.
  always_comb begin
    bus_addr  = last_addr_reg;
    bus_data  = last_data_reg;
    bus_write = 1'b0;
    case (state_reg)
      CPU_OWN: begin
        bus_addr  = cpu_addr;
        bus_data  = cpu_data;
        bus_write = cpu_write;
      end
      ACC_OWN: begin
        bus_addr  = acc_addr;
        bus_data  = acc_data;
        bus_write = acc_write;
      end
      default: ;
    endcase
  end

  assign arb_res  = arb_res_reg;
  assign cpu_hold = cpu_hold_reg;
  assign irq      = irq_reg;
  assign arb_tmo  = arb_tmo_reg;

endmodule

// File: tb/tb_cal_bus_arb.sv
// Bench for cal_bus_arb. It runs two instances side by side on one stimulus:
//   instance 0: HOLD_MAX=64, GNT_DLY=1
//   instance 1: HOLD_MAX=4,  GNT_DLY=2
// A behavioural ownership model predicts every output of both instances on
// every cycle. Directed literal checks pin the model's timing.
module tb_cal_bus_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = '0, acc_addr = '0;
  logic [7:0]  cpu_data = '0, acc_data = '0;
  logic        cpu_write = 0, cpu_lock = 0, acc_req = 0, acc_write = 0;
  logic        acc_int = 0, irq_ack = 0, tmo_clr = 0;

  logic [1:0]  cpu_hold_v, arb_res_v, bus_write_v, irq_v, arb_tmo_v;
  logic [15:0] bus_addr_v [2];
  logic [7:0]  bus_data_v [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cal_bus_arb #(.HOLD_MAX(64), .GNT_DLY(1)) u_a (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_write(cpu_write), .cpu_lock(cpu_lock), .cpu_hold(cpu_hold_v[0]),
    .acc_req(acc_req), .arb_res(arb_res_v[0]), .acc_addr(acc_addr),
    .acc_data(acc_data), .acc_write(acc_write), .acc_int(acc_int),
    .bus_addr(bus_addr_v[0]), .bus_data(bus_data_v[0]), .bus_write(bus_write_v[0]),
    .irq(irq_v[0]), .irq_ack(irq_ack), .arb_tmo(arb_tmo_v[0]), .tmo_clr(tmo_clr)
  );

  cal_bus_arb #(.HOLD_MAX(4), .GNT_DLY(2)) u_b (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_write(cpu_write), .cpu_lock(cpu_lock), .cpu_hold(cpu_hold_v[1]),
    .acc_req(acc_req), .arb_res(arb_res_v[1]), .acc_addr(acc_addr),
    .acc_data(acc_data), .acc_write(acc_write), .acc_int(acc_int),
    .bus_addr(bus_addr_v[1]), .bus_data(bus_data_v[1]), .bus_write(bus_write_v[1]),
    .irq(irq_v[1]), .irq_ack(irq_ack), .arb_tmo(arb_tmo_v[1]), .tmo_clr(tmo_clr)
  );

  // ---------------- behavioural model ----------------
  // Ownership is described by counters:
  //   m_dead: dead cycle number before a grant (0 = not waiting)
  //   m_ten:  granted cycle number (0 = not granted)
  //   m_rel:  1 during the single release cycle
  //   m_own:  consecutive CPU-owned cycles since the last release (saturates at 2)
  int          m_dead [2], m_ten [2], m_rel [2], m_own [2];
  logic        m_tmo [2], m_irq [2], m_prev [2];
  logic [15:0] m_laddr [2];
  logic [7:0]  m_ldata [2];

  function automatic int hold_p(int i);
    return (i == 0) ? 64 : 4;
  endfunction

  function automatic int dly_p(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic bit cpu_side(int i);
    return (m_dead[i] == 0) && (m_ten[i] == 0) && (m_rel[i] == 0);
  endfunction

  function automatic logic [15:0] e_addr(int i);
    if (m_ten[i] > 0) return acc_addr;
    if (cpu_side(i)) return cpu_addr;
    return m_laddr[i];
  endfunction

  function automatic logic [7:0] e_data(int i);
    if (m_ten[i] > 0) return acc_data;
    if (cpu_side(i)) return cpu_data;
    return m_ldata[i];
  endfunction

  function automatic logic e_write(int i);
    if (m_ten[i] > 0) return acc_write;
    if (cpu_side(i)) return cpu_write;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dead[i] = 0; m_ten[i] = 0; m_rel[i] = 0; m_own[i] = 2;
      m_tmo[i] = 0; m_irq[i] = 0; m_prev[i] = 0;
      m_laddr[i] = '0; m_ldata[i] = '0;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      bit cut;
      cut = 0;
      m_laddr[i] = e_addr(i);
      m_ldata[i] = e_data(i);
      if (acc_int && !m_prev[i]) m_irq[i] = 1;
      else if (irq_ack) m_irq[i] = 0;
      m_prev[i] = acc_int;
      if (m_rel[i] != 0) begin
        m_rel[i] = 0;
        m_own[i] = 1;
      end else if (m_dead[i] > 0) begin
        if (!acc_req) begin m_dead[i] = 0; m_rel[i] = 1; end
        else if (m_dead[i] == dly_p(i)) begin m_dead[i] = 0; m_ten[i] = 1; end
        else m_dead[i]++;
      end else if (m_ten[i] > 0) begin
        if (!acc_req) begin m_ten[i] = 0; m_rel[i] = 1; end
        else if (m_ten[i] == hold_p(i)) begin m_ten[i] = 0; m_rel[i] = 1; cut = 1; end
        else m_ten[i]++;
      end else begin
        if (acc_req && !cpu_lock && m_own[i] >= 2) begin
          m_dead[i] = 1;
          m_own[i] = 0;
        end else if (m_own[i] < 2) begin
          m_own[i]++;
        end
      end
      if (cut) m_tmo[i] = 1;
      else if (tmo_clr) m_tmo[i] = 0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arb_res[%0d]", i), 32'(arb_res_v[i]), 32'(m_ten[i] > 0));
      chk($sformatf("cpu_hold[%0d]", i), 32'(cpu_hold_v[i]), 32'(!cpu_side(i)));
      chk($sformatf("bus_addr[%0d]", i), 32'(bus_addr_v[i]), 32'(e_addr(i)));
      chk($sformatf("bus_data[%0d]", i), 32'(bus_data_v[i]), 32'(e_data(i)));
      chk($sformatf("bus_write[%0d]", i), 32'(bus_write_v[i]), 32'(e_write(i)));
      chk($sformatf("irq[%0d]", i), 32'(irq_v[i]), 32'(m_irq[i]));
      chk($sformatf("arb_tmo[%0d]", i), 32'(arb_tmo_v[i]), 32'(m_tmo[i]));
    end
  endtask

  // One clock cycle: compare with settled inputs, clock the model, and
  // return at the falling edge, ready for new inputs.
  task automatic step();
    if (rst) model_reset();
    #1 compare();
    @(posedge clk);
    if (rst) model_reset();
    else model_clock();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, cnt, own;
    model_reset();
    #1 rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state.
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_arb_res", 32'(arb_res_v[i]), 0);
      chk("rst_cpu_hold", 32'(cpu_hold_v[i]), 0);
      chk("rst_irq", 32'(irq_v[i]), 0);
      chk("rst_arb_tmo", 32'(arb_tmo_v[i]), 0);
    end

    // 1: CPU write passes straight through.
    cpu_addr = 16'h1234; cpu_data = 8'h5A; cpu_write = 1;
    #1;
    chk("t1_addr", 32'(bus_addr_v[0]), 32'h1234);
    chk("t1_data", 32'(bus_data_v[0]), 32'h5A);
    chk("t1_write", 32'(bus_write_v[0]), 1);
    chk("t1_hold", 32'(cpu_hold_v[0]), 0);
    step();
    cpu_write = 0;

    // 2: grant and release (instance 0, GNT_DLY=1).
    acc_req = 1; step();                                   // cycle t
    #1 chk("t2_hold_t1", 32'(cpu_hold_v[0]), 1);
    chk("t2_res_t1", 32'(arb_res_v[0]), 0);
    step();
    acc_addr = 16'h8000; acc_data = 8'h0F; acc_write = 1;  // t+2
    #1 chk("t2_res_t2", 32'(arb_res_v[0]), 1);
    chk("t2_addr", 32'(bus_addr_v[0]), 32'h8000);
    chk("t2_data", 32'(bus_data_v[0]), 32'h0F);
    chk("t2_write", 32'(bus_write_v[0]), 1);
    repeat (4) step();
    acc_req = 0;                                           // t+6
    #1 chk("t2_res_t6", 32'(arb_res_v[0]), 1);
    step();
    #1 chk("t2_res_t7", 32'(arb_res_v[0]), 0);             // t+7
    chk("t2_hold_t7", 32'(cpu_hold_v[0]), 1);
    chk("t2_wr_t7", 32'(bus_write_v[0]), 0);
    step();
    #1 chk("t2_hold_t8", 32'(cpu_hold_v[0]), 0);           // t+8
    acc_write = 0;
    repeat (3) step();

    // 3: cpu_lock blocks the handover; the dead cycle never writes.
    cpu_lock = 1; acc_req = 1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3_locked_hold", 32'(cpu_hold_v[0]), 0);
      step();
    end
    cpu_lock = 0;
    #1 chk("t3_unlock_hold", 32'(cpu_hold_v[0]), 0);
    step();
    acc_write = 1;
    #1 chk("t3_toacc_hold", 32'(cpu_hold_v[0]), 1);
    chk("t3_toacc_res", 32'(arb_res_v[0]), 0);
    chk("t3_toacc_wr", 32'(bus_write_v[0]), 0);
    chk("t3_toacc_addr", 32'(bus_addr_v[0]), 32'h1234);
    step();
    acc_req = 0; acc_write = 0;
    repeat (5) step();

    // 4: timeout (instance 1, HOLD_MAX=4).
    acc_req = 1;
    n = 0;
    #1;
    while (arb_res_v[1] !== 1'b1 && n < 20) begin step(); #1; n++; end
    chk("t4_grant1_seen", 32'(n < 20), 1);
    cnt = 0;
    while (arb_res_v[1] === 1'b1 && cnt < 10) begin cnt++; step(); #1; end
    chk("t4_tenure_len", 32'(cnt), 4);
    chk("t4_tmo_set", 32'(arb_tmo_v[1]), 1);
    chk("t4_rel_hold", 32'(cpu_hold_v[1]), 1);
    step(); #1;
    own = 0;
    while (cpu_hold_v[1] === 1'b0 && own < 10) begin own++; step(); #1; end
    chk("t4_cpu_owned", 32'(own >= 1 && own < 10), 1);
    n = 0;
    while (arb_res_v[1] !== 1'b1 && n < 20) begin step(); #1; n++; end
    chk("t4_grant2_seen", 32'(n < 20), 1);
    tmo_clr = 1; step();                                   // grant cycle 1
    tmo_clr = 0;
    #1 chk("t4_tmo_cleared", 32'(arb_tmo_v[1]), 0);
    step(); step();
    tmo_clr = 1;                                           // grant cycle 4
    #1 chk("t4_res_c4", 32'(arb_res_v[1]), 1);
    step();
    tmo_clr = 0;
    #1 chk("t4_tmo_wins", 32'(arb_tmo_v[1]), 1);
    chk("t4_res_cut", 32'(arb_res_v[1]), 0);
    acc_req = 0;
    repeat (4) step();

    // 5: interrupt edge detection.
    acc_int = 1; step();
    acc_int = 0;
    #1 chk("t5_irq_set", 32'(irq_v[0]), 1);
    step();
    #1 chk("t5_irq_latched", 32'(irq_v[0]), 1);
    irq_ack = 1; step();
    irq_ack = 0;
    #1 chk("t5_irq_ack", 32'(irq_v[0]), 0);
    acc_int = 1; step();
    #1 chk("t5_irq_edge2", 32'(irq_v[0]), 1);
    irq_ack = 1; step();
    irq_ack = 0;
    #1 chk("t5_irq_ack2", 32'(irq_v[0]), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      #1 chk("t5_level_no_refire", 32'(irq_v[0]), 0);
    end
    acc_int = 0; step();
    acc_int = 1; irq_ack = 1; step();
    irq_ack = 0;
    #1 chk("t5_set_wins", 32'(irq_v[0]), 1);
    acc_int = 0;

    // 6: async reset while instance 0 holds the bus.
    acc_req = 1;
    n = 0;
    #1;
    while (arb_res_v[0] !== 1'b1 && n < 20) begin step(); #1; n++; end
    chk("t6_grant_seen", 32'(n < 20), 1);
    #1 rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t6_rst_res", 32'(arb_res_v[i]), 0);
      chk("t6_rst_hold", 32'(cpu_hold_v[i]), 0);
      chk("t6_rst_irq", 32'(irq_v[i]), 0);
      chk("t6_rst_tmo", 32'(arb_tmo_v[i]), 0);
    end
    step();
    rst = 0;
    #1 chk("t6_after_hold", 32'(cpu_hold_v[0]), 0);
    chk("t6_after_addr", 32'(bus_addr_v[0]), 32'(cpu_addr));
    step();
    #1 chk("t6_regrant_hold", 32'(cpu_hold_v[0]), 1);
    acc_req = 0;
    repeat (3) step();

    // Randomized traffic, checked every cycle by the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) acc_req = ~acc_req;
      if ($urandom_range(3) == 0) acc_int = ~acc_int;
      cpu_lock  = ($urandom_range(4) == 0);
      cpu_addr  = 16'($urandom);
      cpu_data  = 8'($urandom);
      cpu_write = 1'($urandom);
      acc_addr  = 16'($urandom);
      acc_data  = 8'($urandom);
      acc_write = 1'($urandom);
      irq_ack   = ($urandom_range(5) == 0);
      tmo_clr   = ($urandom_range(7) == 0);
      rst       = ($urandom_range(499) == 0);
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
